per_hs_rx_fifo: RTL and testbench
=================================

// Module: per_hs_rx_fifo
// PURPOSE
//  Peripheral-side receiver for the 4-phase send/ack link driven by the CPU block. It generalises the
//  single-register peripheral: data width is parametrised, received words queue in a DEPTH-entry
//  FIFO, and ack is withheld while the FIFO is full (back-pressure). A valid/ready port hands
//  words to local peripheral logic. Single clock domain, shared with the CPU sender.
// PARAMETERS
//  DATA_W  4  width of in_per_dados / out_per_dados
//  DEPTH   4  FIFO entries; power of two, >=2
//  CNT_W   $clog2(DEPTH)+1  width of fill level
// PORTS
//  per_clk        in   1       clock; all logic on rising edge
//  per_rst        in   1       reset, synchronous, active-high
//  per_send       in   1       request from CPU (4-phase)
//  in_per_dados   in   DATA_W  word from CPU; stable while per_send=1
//  per_ack        out  1       acknowledge to CPU, registered
//  out_per_valid  out  1       FIFO not empty
//  out_per_dados  out  DATA_W  FIFO head word, valid when out_per_valid=1
//  out_per_ready  in   1       consumer pops head when valid&ready at clock edge
//  per_nivel      out  CNT_W   current fill level, 0..DEPTH
// BEHAVIOUR
//  Reset: per_ack=0, FIFO empty (per_nivel=0, out_per_valid=0), pointers 0, state SYNC.
//  FSM states:
//   SYNC: per_ack=0; go IDLE once per_send=0 is sampled. A per_send held high through reset is
//         never taken as a new word.
//   IDLE: per_ack=0; if per_send=1 and per_nivel<DEPTH: write in_per_dados, per_ack<=1, go ACK.
//         If full: stay IDLE, per_ack stays 0, and nothing is written until space frees.
//   ACK:  per_ack=1; stay while per_send=1, with no further writes; on per_send=0: per_ack<=0, go IDLE.
//  Latency: per_send seen high at edge k (not full) -> word written and per_ack=1 after edge k.
//   per_send seen low at edge m in ACK -> per_ack=0 after edge m. One word per full 4-phase cycle.
//  Full check uses the registered per_nivel. A pop on the same edge frees the slot only for the
//   next edge, so a full FIFO with a simultaneous pop does not accept that cycle.
//  Push and pop on the same edge: per_nivel unchanged, both pointers advance.
//  Pop when empty: ignored. Overflow cannot occur.
//  Pointers wrap modulo DEPTH. per_nivel saturates logically at DEPTH.
//  out_per_dados: combinational read of the head entry. Its value is don't-care when empty.
//  Reset mid-handshake: ack drops the next cycle, FIFO contents are discarded, and SYNC waits for send=0.
// CONFIGURATION
//  Macro PER_PARITY_EN:
//   defined: extra input in_per_par (1 bit), which gives even parity over {in_per_par,in_per_dados}.
//     Extra output per_erro (1 bit, reset 0). A word with bad parity is still acked normally but
//     is NOT written. per_erro sets sticky to 1 and clears only on per_rst.
//   undefined: no in_per_par and no per_erro ports; every accepted word is written.
// STRUCTURE
//  Package hs_pkg: typedef enum {HS_SYNC, HS_IDLE, HS_ACK} hs_state_t; parity helper function.
//  Sub-module hs_sync_fifo (DATA_W, DEPTH): push/pop, head data, level. Its push is driven by the
//   IDLE->ACK transition (gated by parity when enabled).
// TESTING
//  1 Reset, then send=1 with dados=4'hA, drop send after ack -> ack high 1 cycle after send; valid=1,
//    out=4'hA, nivel=1.
//  2 Four words 1,2,3,4 with ready=0, then a fifth word 5 -> first four acked, nivel=4; fifth ack
//    stays 0. Pop once -> ack rises next-next edge and 5 is enqueued. Drain order is 1,2,3,4,5.
//  3 Full FIFO, send=1 and pop on the same edge -> no ack that cycle, ack the following cycle.
//  4 per_rst pulsed while in ACK with send held 1 -> ack=0, nivel=0, no write. After send falls and
//    rises with 4'h7 -> exactly one word, 4'h7.
//  5 Continuous ready=1 and back-to-back handshakes -> nivel never exceeds 1, order preserved,
//    wrap past DEPTH*3 words.
//  6 PER_PARITY_EN: word 4'h3 with par=1 (bad) -> acked, not stored, per_erro=1. Next good word
//    stored, and per_erro stays 1 until reset.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared types and helpers for the peripheral-side 4-phase receiver.
// The parity helper is only used when the design is built with PER_PARITY_EN.
package hs_pkg;

  typedef enum logic [1:0] {
    HS_SYNC = 2'd0,
    HS_IDLE = 2'd1,
    HS_ACK  = 2'd2
  } hs_state_t;

  localparam int PAR_MAX_W = 64;

  // The result is 1 when v holds an odd number of ones.
  // Even parity over a word is good when this returns 0.
  function automatic logic parity_odd(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/hs_sync_fifo.sv
// Single-clock FIFO for DEPTH entries, where DEPTH is a power of two.
// The head word is read combinationally, and the fill level is held in a register.
module hs_sync_fifo
  import hs_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              valid,
  output logic [CNT_W-1:0]  level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]  level_r;
  logic              full_s;
  logic              empty_s;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full_s    = (level_r == CNT_W'(DEPTH));
  assign empty_s   = (level_r == {CNT_W{1'b0}});
  assign push_ok_s = push & ~full_s;
  assign pop_ok_s  = pop & ~empty_s;

  // Storage array. It has no reset because entries past the level are don't-care.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH. The level stays unchanged on a simultaneous push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + CNT_W'(1);
        2'b01:   level_r <= level_r - CNT_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign valid     = ~empty_s;
  assign level     = level_r;

endmodule

// File: rtl/per_hs_rx_fifo.sv
// Peripheral receiver for the 4-phase send/ack link. Accepted words are queued in an hs_sync_fifo.
// A full FIFO holds back ack. Optional macro PER_PARITY_EN adds in_per_par and per_erro.
module per_hs_rx_fifo
  import hs_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              per_clk,
  input  logic              per_rst,
  input  logic              per_send,
  input  logic [DATA_W-1:0] in_per_dados,
`ifdef PER_PARITY_EN
  input  logic              in_per_par,
  output logic              per_erro,
`endif
  output logic              per_ack,
  output logic              out_per_valid,
  output logic [DATA_W-1:0] out_per_dados,
  input  logic              out_per_ready,
  output logic [CNT_W-1:0]  per_nivel
);

  hs_state_t        state_r;
  hs_state_t        state_nxt_s;
  logic             ack_r;
  logic             ack_nxt_s;
  logic             take_s;
  logic             push_s;
  logic             par_ok_s;
  logic             full_s;
  logic [CNT_W-1:0] level_s;

  assign full_s = (level_s == CNT_W'(DEPTH));

  // State and ack registers.
  always_ff @(posedge per_clk) begin
    if (per_rst) begin
      state_r <= HS_SYNC;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ack_r   <= ack_nxt_s;
    end
  end

  // Next state. SYNC absorbs a send that was already high when reset was applied.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      HS_SYNC: begin
        if (!per_send) state_nxt_s = HS_IDLE;
        else           state_nxt_s = HS_SYNC;
      end
      HS_IDLE: begin
        if (per_send && !full_s) state_nxt_s = HS_ACK;
        else                     state_nxt_s = HS_IDLE;
      end
      HS_ACK: begin
        if (!per_send) state_nxt_s = HS_IDLE;
        else           state_nxt_s = HS_ACK;
      end
      default: state_nxt_s = HS_SYNC;
    endcase
  end

  // Output decode. A word is taken only on the IDLE to ACK transition.
  always_comb begin
    take_s    = 1'b0;
    ack_nxt_s = 1'b0;
    if (state_r == HS_IDLE && state_nxt_s == HS_ACK) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
    if (state_nxt_s == HS_ACK) begin
      ack_nxt_s = 1'b1;
    end else begin
      ack_nxt_s = 1'b0;
    end
  end

`ifdef PER_PARITY_EN
  logic erro_r;

  assign par_ok_s = ~parity_odd(PAR_MAX_W'({in_per_par, in_per_dados}));

  // Sticky error flag. It is set by an acked word that has bad parity.
  always_ff @(posedge per_clk) begin
    if (per_rst) begin
      erro_r <= 1'b0;
    end else if (take_s && !par_ok_s) begin
      erro_r <= 1'b1;
    end else begin
      erro_r <= erro_r;
    end
  end

  assign per_erro = erro_r;
`else
  assign par_ok_s = 1'b1;
`endif

  assign push_s = take_s & par_ok_s;

  hs_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (per_clk),
    .rst       (per_rst),
    .push      (push_s),
    .push_data (in_per_dados),
    .pop       (out_per_ready),
    .head_data (out_per_dados),
    .valid     (out_per_valid),
    .level     (level_s)
  );

  assign per_ack   = ack_r;
  assign per_nivel = level_s;

endmodule

// File: tb/tb_per_hs_rx_fifo.sv
// Directed scoreboard bench for per_hs_rx_fifo. Its parity steps are built only with PER_PARITY_EN.
module tb_per_hs_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [3:0] dados;
  logic       ack;
  logic       valid;
  logic [3:0] dout;
  logic       ready;
  logic [2:0] nivel;
`ifdef PER_PARITY_EN
  logic       par;
  logic       erro;
`endif

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  per_hs_rx_fifo #(.DATA_W(4), .DEPTH(4), .CNT_W(3)) dut (
    .per_clk       (clk),
    .per_rst       (rst),
    .per_send      (send),
    .in_per_dados  (dados),
`ifdef PER_PARITY_EN
    .in_per_par    (par),
    .per_erro      (erro),
`endif
    .per_ack       (ack),
    .out_per_valid (valid),
    .out_per_dados (dout),
    .out_per_ready (ready),
    .per_nivel     (nivel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; send = 1'b0; ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic send_ok(input logic [3:0] d, input string tag);
    send = 1'b1; dados = d;
    step();
    chk({tag, "_ack_hi"}, 32'(ack), 32'd1);
    exp_q.push_back(d);
    send = 1'b0;
    step();
    chk({tag, "_ack_lo"}, 32'(ack), 32'd0);
  endtask

  task automatic check_head(input string tag);
    logic [3:0] e;
    e = 4'h0;
    chk({tag, "_qsize"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_data"}, 32'(dout), 32'(e));
  endtask

  task automatic pop_one(input string tag);
    check_head(tag);
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; send = 1'b0; dados = 4'h0; ready = 1'b0;
`ifdef PER_PARITY_EN
    par = 1'b0;
`endif
    step();

    // 1: reset state and single word
    do_reset();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_nivel", 32'(nivel), 32'd0);
    send_ok(4'hA, "t1");
    chk("t1_nivel", 32'(nivel), 32'd1);
    pop_one("t1_pop");
    chk("t1_empty", 32'(valid), 32'd0);

    // 2: fill, back-pressure, pop frees a slot
    for (int i = 1; i <= 4; i++) send_ok(4'(i), "t2_fill");
    chk("t2_nivel_full", 32'(nivel), 32'd4);
    send = 1'b1; dados = 4'h5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_ack_held", 32'(ack), 32'd0);
    end
    pop_one("t2_pop1");
    chk("t2_ack_popedge", 32'(ack), 32'd0);
    chk("t2_nivel3", 32'(nivel), 32'd3);
    step();
    chk("t2_ack_rise", 32'(ack), 32'd1);
    exp_q.push_back(4'h5);
    chk("t2_nivel4", 32'(nivel), 32'd4);
    send = 1'b0;
    step();
    chk("t2_ack_fall", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) pop_one("t2_drain");
    chk("t2_empty", 32'(valid), 32'd0);

    // 3: full FIFO with a pop on the same edge as send
    for (int i = 6; i <= 9; i++) send_ok(4'(i), "t3_fill");
    chk("t3_nivel_full", 32'(nivel), 32'd4);
    check_head("t3_pop");
    send = 1'b1; dados = 4'hB; ready = 1'b1;
    step();
    ready = 1'b0;
    chk("t3_no_ack", 32'(ack), 32'd0);
    chk("t3_nivel3", 32'(nivel), 32'd3);
    step();
    chk("t3_ack_next", 32'(ack), 32'd1);
    exp_q.push_back(4'hB);
    chk("t3_nivel4", 32'(nivel), 32'd4);
    send = 1'b0;
    step();
    for (int i = 0; i < 4; i++) pop_one("t3_drain");
    chk("t3_empty", 32'(valid), 32'd0);

    // 4: reset in ACK with send held high
    send = 1'b1; dados = 4'hC;
    step();
    chk("t4_ack", 32'(ack), 32'd1);
    chk("t4_nivel1", 32'(nivel), 32'd1);
    rst = 1'b1;
    step();
    exp_q.delete();
    chk("t4_rst_ack", 32'(ack), 32'd0);
    chk("t4_rst_nivel", 32'(nivel), 32'd0);
    chk("t4_rst_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t4_sync_ack", 32'(ack), 32'd0);
      chk("t4_sync_nivel", 32'(nivel), 32'd0);
    end
    send = 1'b0;
    step();
    send_ok(4'h7, "t4");
    chk("t4_nivel_one", 32'(nivel), 32'd1);
    pop_one("t4_pop");
    chk("t4_empty", 32'(valid), 32'd0);

    // 5: streaming with ready held, wraps pointers several times
    ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send = 1'b1; dados = 4'(i * 3 + 1);
      exp_q.push_back(4'(i * 3 + 1));
      step();
      chk("t5_ack_hi", 32'(ack), 32'd1);
      chk("t5_nivel1", 32'(nivel), 32'd1);
      check_head("t5_head");
      send = 1'b0;
      step();
      chk("t5_ack_lo", 32'(ack), 32'd0);
      chk("t5_nivel0", 32'(nivel), 32'd0);
    end
    ready = 1'b0;

`ifdef PER_PARITY_EN
    // 6: bad parity word is acked but dropped, and the error flag is sticky
    do_reset();
    chk("t6_erro_rst", 32'(erro), 32'd0);
    par = 1'b1; send = 1'b1; dados = 4'h3;
    step();
    chk("t6_bad_ack", 32'(ack), 32'd1);
    send = 1'b0;
    step();
    chk("t6_bad_nivel", 32'(nivel), 32'd0);
    chk("t6_erro_set", 32'(erro), 32'd1);
    par = 1'b0;
    send_ok(4'h5, "t6_good");
    chk("t6_good_nivel", 32'(nivel), 32'd1);
    chk("t6_erro_sticky", 32'(erro), 32'd1);
    pop_one("t6_pop");
    chk("t6_erro_still", 32'(erro), 32'd1);
    do_reset();
    chk("t6_erro_clr", 32'(erro), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
